// File: rtl/jtdd_sndcom.sv
// ============================================================================
// Module   : jtdd_sndcom
// Brief    : Main-to-sound CPU command queue with latch view, irq and
//            stretched sound-CPU reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtdd_sndcom #(
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    parameter int RSTW      = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] snd_latch,
    input  logic       snd_irq,
    input  logic       snd_rstb,
    input  logic       latch_rd,
    output logic [7:0] cmd,
    output logic       irq,
    output logic       snd_rst,
    output logic       ovf,
    output logic [4:0] level
);

    localparam int       c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int       c_MEMN  = 1 << c_PW;
    localparam logic [4:0] c_DEPTH = 5'(DEPTH);
    localparam logic [7:0] c_RSTW  = 8'(RSTW);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STRETCH = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [7:0]      r_cnt, w_cnt_next;
    logic [7:0]      r_mem [0:c_MEMN-1];
    logic [c_PW-1:0] r_wr, r_rd, w_wr_next, w_rd_next, w_waddr;
    logic [4:0]      r_level, w_level_next;
    logic [7:0]      r_cmd, w_cmd_next;
    logic            r_irq, r_ovf, w_ovf_next, r_snd_rst;
    logic            r_irq_d, r_rd_d;
    logic            w_push, w_pop, w_flush, w_empty, w_full;
    logic            w_do_pop, w_do_push, w_we;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    function automatic logic [c_PW-1:0] f_dec(input logic [c_PW-1:0] p);
        return (p == '0) ? c_LAST : p - c_PW'(1);
    endfunction

    // Reset sequencer: HOLD while requested, then count RSTW cen pulses.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!snd_rstb) begin
            w_state_next = ST_HOLD;
            w_cnt_next   = c_RSTW;
        end else begin
            case (r_state)
                ST_RUN: ;
                ST_HOLD: begin
                    w_state_next = ST_STRETCH;
                    w_cnt_next   = c_RSTW;
                end
                ST_STRETCH: begin
                    if (cen) begin
                        w_cnt_next = r_cnt - 8'd1;
                        if (r_cnt == 8'd1)
                            w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = c_RSTW;
                end
            endcase
        end
    end

    always_comb begin
        w_push       = snd_irq & ~r_irq_d;
        w_pop        = latch_rd & ~r_rd_d;
        w_flush      = ~snd_rstb | (r_state == ST_HOLD);
        w_empty      = (r_level == 5'd0);
        w_full       = (r_level == c_DEPTH);
        w_do_pop     = w_pop & ~w_flush & (r_state == ST_RUN) & ~w_empty;
        w_do_push    = w_push & ~w_flush;
        w_we         = 1'b0;
        w_waddr      = r_wr;
        w_wr_next    = r_wr;
        w_rd_next    = r_rd;
        w_level_next = r_level;
        w_ovf_next   = r_ovf;
        w_cmd_next   = r_cmd;
        if (w_flush) begin
            w_wr_next    = '0;
            w_rd_next    = '0;
            w_level_next = 5'd0;
            w_ovf_next   = 1'b0;
        end else begin
            if (w_do_pop)
                w_rd_next = f_inc(r_rd);
            if (w_do_push) begin
                // A pop in the same cycle frees the slot, so a full FIFO still accepts.
                if (!w_full || w_do_pop) begin
                    w_we      = 1'b1;
                    w_wr_next = f_inc(r_wr);
                end else if (OVERWRITE != 0) begin
                    w_we    = 1'b1;
                    w_waddr = f_dec(r_wr);
                end else begin
                    w_ovf_next = 1'b1;
                end
            end
            if (w_do_push && !w_full && !w_do_pop)
                w_level_next = r_level + 5'd1;
            else if (w_do_pop && !w_do_push)
                w_level_next = r_level - 5'd1;
        end
        if (w_level_next != 5'd0)
            w_cmd_next = (w_we && (w_waddr == w_rd_next)) ? snd_latch : r_mem[w_rd_next];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we)
            r_mem[w_waddr] <= snd_latch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HOLD;
            r_cnt     <= c_RSTW;
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= 5'd0;
            r_cmd     <= 8'h00;
            r_irq     <= 1'b0;
            r_ovf     <= 1'b0;
            r_snd_rst <= 1'b1;
            r_irq_d   <= 1'b0;
            r_rd_d    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_wr      <= w_wr_next;
            r_rd      <= w_rd_next;
            r_level   <= w_level_next;
            r_cmd     <= w_cmd_next;
            r_irq     <= (w_level_next != 5'd0);
            r_ovf     <= w_ovf_next;
            r_snd_rst <= (w_state_next != ST_RUN);
            r_irq_d   <= snd_irq;
            r_rd_d    <= latch_rd;
        end
    end

    assign cmd     = r_cmd;
    assign irq     = r_irq;
    assign snd_rst = r_snd_rst;
    assign ovf     = r_ovf;
    assign level   = r_level;

endmodule

`default_nettype wire

// File: tb/tb_jtdd_sndcom.sv
// ============================================================================
// Module   : tb_jtdd_sndcom
// Brief    : Bench for jtdd_sndcom; a 4-deep dropping queue and a 1-deep
//            overwriting latch driven in parallel against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jtdd_sndcom;

    localparam int c_RSTW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic [7:0] snd_latch = 8'h00;
    logic       snd_irq = 1'b0;
    logic       snd_rstb = 1'b1;
    logic       latch_rd = 1'b0;

    logic [7:0] cmd_a, cmd_b;
    logic       irq_a, irq_b, srst_a, srst_b, ovf_a, ovf_b;
    logic [4:0] lvl_a, lvl_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    jtdd_sndcom #(.DEPTH(4), .OVERWRITE(0), .RSTW(c_RSTW)) u_dut_a (
        .clk(clk), .rst(rst), .cen(cen), .snd_latch(snd_latch), .snd_irq(snd_irq),
        .snd_rstb(snd_rstb), .latch_rd(latch_rd), .cmd(cmd_a), .irq(irq_a),
        .snd_rst(srst_a), .ovf(ovf_a), .level(lvl_a)
    );

    jtdd_sndcom #(.DEPTH(1), .OVERWRITE(1), .RSTW(c_RSTW)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen), .snd_latch(snd_latch), .snd_irq(snd_irq),
        .snd_rstb(snd_rstb), .latch_rd(latch_rd), .cmd(cmd_b), .irq(irq_b),
        .snd_rst(srst_b), .ovf(ovf_b), .level(lvl_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte queues plus a remaining-pulse count.
    logic [7:0] mq[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] m_cmd_a = 8'h00, m_cmd_b = 8'h00;
    bit         m_ovf_a = 1'b0, m_ovf_b = 1'b0;
    bit         m_hold = 1'b1;
    int         m_left = c_RSTW;
    bit         m_pirq = 1'b0, m_prd = 1'b0;

    task automatic fifo_upd(input int d, input bit ow, input bit pu, input bit po,
                            input logic [7:0] din, inout logic [7:0] c, inout bit ov);
        if (po && mq.size() > 0)
            void'(mq.pop_front());
        if (pu) begin
            if (mq.size() < d) mq.push_back(din);
            else if (ow)       mq[$] = din;
            else               ov = 1'b1;
        end
        if (mq.size() > 0)
            c = mq[0];
    endtask

    task automatic model_tick();
        bit pu, po, run;
        pu = snd_irq && !m_pirq;
        po = latch_rd && !m_prd;
        if (rst) begin
            qa.delete(); qb.delete();
            m_cmd_a = 8'h00; m_cmd_b = 8'h00;
            m_ovf_a = 1'b0;  m_ovf_b = 1'b0;
            m_hold = 1'b1;   m_left = c_RSTW;
            m_pirq = 1'b0;   m_prd = 1'b0;
            return;
        end
        m_pirq = snd_irq;
        m_prd  = latch_rd;
        if (!snd_rstb) begin
            m_hold = 1'b1; m_left = c_RSTW;
            qa.delete(); qb.delete();
            m_ovf_a = 1'b0; m_ovf_b = 1'b0;
        end else if (m_hold) begin
            m_hold = 1'b0; m_left = c_RSTW;
        end else begin
            run = (m_left == 0);
            if (!run && cen) m_left--;
            mq = qa; fifo_upd(4, 1'b0, pu, po && run, snd_latch, m_cmd_a, m_ovf_a); qa = mq;
            mq = qb; fifo_upd(1, 1'b1, pu, po && run, snd_latch, m_cmd_b, m_ovf_b); qb = mq;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        bit srst;
        srst = m_hold || (m_left > 0);
        chk("a_cmd",   cmd_a,         m_cmd_a);
        chk("a_irq",   8'(irq_a),     8'(qa.size() > 0));
        chk("a_srst",  8'(srst_a),    8'(srst));
        chk("a_ovf",   8'(ovf_a),     8'(m_ovf_a));
        chk("a_level", 8'(lvl_a),     8'(qa.size()));
        chk("b_cmd",   cmd_b,         m_cmd_b);
        chk("b_irq",   8'(irq_b),     8'(qb.size() > 0));
        chk("b_srst",  8'(srst_b),    8'(srst));
        chk("b_ovf",   8'(ovf_b),     8'(m_ovf_b));
        chk("b_level", 8'(lvl_b),     8'(qb.size()));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            cen = (cyc % 4 == 3);
            cyc++;
            @(posedge clk);
            model_tick();
            #1;
            check_all();
        end
    endtask

    task automatic push(input logic [7:0] v);
        snd_latch = v; snd_irq = 1'b1; step(1);
        snd_irq = 1'b0; step(1);
    endtask

    task automatic pop();
        latch_rd = 1'b1; step(1);
        latch_rd = 1'b0; step(1);
    endtask

    // Counts cen pulses until the sound reset drops; must start inside STRETCH.
    task automatic wait_release(input string tag, input int exp_pulses);
        int pulses = 0;
        int k = 0;
        while (srst_a === 1'b1 && k < 200) begin
            step(1);
            if (cen) pulses++;
            k++;
        end
        chk(tag, 8'(pulses), 8'(exp_pulses));
    endtask

    initial begin
        rst = 1'b1; snd_rstb = 1'b1;
        step(2);
        chk("rst_srst", 8'(srst_a), 8'd1);
        chk("rst_cmd",  cmd_a, 8'h00);
        rst = 1'b0;
        step(1);
        wait_release("stretch_pulses", c_RSTW);
        chk("run_level", 8'(lvl_a), 8'd0);

        // Long strobe -> single push; long read -> single pop.
        snd_latch = 8'h3A; snd_irq = 1'b1; step(6);
        snd_irq = 1'b0; step(1);
        chk("strobe_level", 8'(lvl_a), 8'd1);
        chk("strobe_cmd", cmd_a, 8'h3A);
        latch_rd = 1'b1; step(5);
        latch_rd = 1'b0; step(2);
        chk("read_level", 8'(lvl_a), 8'd0);
        chk("read_cmd", cmd_a, 8'h3A);

        for (int v = 1; v <= 5; v++) push(8'(v));
        chk("full_level", 8'(lvl_a), 8'd4);
        chk("full_ovf", 8'(ovf_a), 8'd1);
        chk("latch_cmd", cmd_b, 8'h05);
        chk("latch_ovf", 8'(ovf_b), 8'd0);
        for (int v = 1; v <= 4; v++) begin
            chk("order", cmd_a, 8'(v));
            pop();
        end
        pop();
        chk("empty_pop_cmd", cmd_a, 8'h04);

        // Flush via sound reset, then a mid-stretch re-assert.
        for (int v = 0; v < 3; v++) push(8'(8'hC0 + v));
        snd_rstb = 1'b0; step(1);
        chk("flush_level", 8'(lvl_a), 8'd0);
        chk("flush_ovf", 8'(ovf_a), 8'd0);
        push(8'hEE);
        chk("hold_push", 8'(lvl_a), 8'd0);
        snd_rstb = 1'b1; step(1);
        begin
            int p = 0;
            int k = 0;
            while (p < 3 && k < 50) begin step(1); if (cen) p++; k++; end
        end
        snd_rstb = 1'b0; step(1);
        snd_rstb = 1'b1; step(1);
        wait_release("reload_pulses", c_RSTW);

        push(8'h10); push(8'h20);
        chk("ow_cmd", cmd_b, 8'h20);
        chk("ow_level", 8'(lvl_b), 8'd1);
        push(8'h30); push(8'h40);
        snd_latch = 8'h55; snd_irq = 1'b1; latch_rd = 1'b1; step(1);
        snd_irq = 1'b0; latch_rd = 1'b0; step(1);
        chk("fullpp_level", 8'(lvl_a), 8'd4);
        chk("fullpp_ovf", 8'(ovf_a), 8'd0);
        pop(); pop(); pop();
        chk("tail_55", cmd_a, 8'h55);
        pop();
        snd_latch = 8'h77; snd_irq = 1'b1; latch_rd = 1'b1; step(1);
        snd_irq = 1'b0; latch_rd = 1'b0; step(1);
        chk("emptypp_level", 8'(lvl_a), 8'd1);
        chk("emptypp_cmd", cmd_a, 8'h77);

        // Randomized traffic, including sound resets and full resets.
        for (int i = 0; i < 1500; i++) begin
            snd_irq   = ($urandom_range(0, 2) == 0);
            latch_rd  = ($urandom_range(0, 3) == 0);
            snd_latch = 8'($urandom);
            snd_rstb  = ($urandom_range(0, 120) != 0);
            rst       = ($urandom_range(0, 500) == 0);
            step(1);
        end
        rst = 1'b0; snd_rstb = 1'b1; snd_irq = 1'b0; latch_rd = 1'b0;
        step(40);
        push(8'hA5);
        rst = 1'b1; step(1);
        rst = 1'b0;
        chk("midrst_level", 8'(lvl_a), 8'd0);
        chk("midrst_cmd", cmd_a, 8'h00);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
